// File: rtl/bj_pkg.sv
// Shared definitions for the multi-seat blackjack table controller.
//   state_t  : table sequencing states
//   result_t : per-seat settlement outcome
//   seat_w() : width of a seat index for a given number of player seats
//              (players plus the dealer, never narrower than one bit)
package bj_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SHUFFLE,
    DEAL,
    PEEK,
    P_TURN,
    P_CARD,
    P_HOLD,
    NEXT_P,
    D_TURN,
    D_CARD,
    D_HOLD,
    SETTLE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_WIN,
    RES_LOSE,
    RES_TIE
  } result_t;

  function automatic int unsigned seat_w(input int unsigned n_players);
    return ((n_players + 1) > 1) ? $clog2(n_players + 1) : 1;
  endfunction

endpackage

// File: rtl/bj_table_controller_edge.sv
// Rising-edge detector for a debounced level button.
//   i_Clk     : clock
//   i_Reset_n : synchronous active-low reset
//   level     : debounced button level
//   rise      : one-cycle pulse, registered, the cycle after the level rises
// A button held high produces exactly one pulse.
module bj_edge_det (
  input  logic i_Clk,
  input  logic i_Reset_n,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
    end
  end

endmodule

// File: rtl/bj_table_controller.sv
// Blackjack table controller: sequences shuffle, initial deal, each player
// seat's turn, the dealer's turn and settlement for N_PLAYERS seats plus a
// dealer (seat index N_PLAYERS).
//
// Ports:
//   i_Clk, i_Reset_n        : clock, synchronous active-low reset
//   i_Hit, i_Stay, i_NewGame: debounced level buttons (edge-detected here)
//   i_Shuffled              : shuffler done
//   i_CardOK                : one-cycle pulse, requested card added
//   i_Hands                 : packed hand values, seat k at [k*HAND_W +: HAND_W]
//   o_ShuffleReq            : high while shuffling
//   o_CardReq, o_CardDest   : registered card request and destination seat
//   o_ActiveSeat            : seat currently acting
//   o_HitInd, o_StayInd     : high during the display hold
//   o_ShowDealer            : dealer hole card visible
//   o_Win, o_Lose, o_Tie    : registered per-seat results
//
// Build option: define BJ_SOFT17_HIT_EN to add input i_DealerSoft; the dealer
// then also hits a soft hand equal to STAND_AT.
module bj_table_controller
  import bj_pkg::*;
#(
  parameter int unsigned N_PLAYERS   = 2,
  parameter int unsigned HAND_W      = 6,
  parameter int unsigned BUST_LIMIT  = 21,
  parameter int unsigned STAND_AT    = 17,
  parameter int unsigned DISPLAY_CYC = 100_000_000
) (
  input  logic                            i_Clk,
  input  logic                            i_Reset_n,
  input  logic                            i_Hit,
  input  logic                            i_Stay,
  input  logic                            i_NewGame,
  input  logic                            i_Shuffled,
  input  logic                            i_CardOK,
`ifdef BJ_SOFT17_HIT_EN
  input  logic                            i_DealerSoft,
`endif
  input  logic [(N_PLAYERS+1)*HAND_W-1:0] i_Hands,
  output logic                            o_ShuffleReq,
  output logic                            o_CardReq,
  output logic [seat_w(N_PLAYERS)-1:0]    o_CardDest,
  output logic [seat_w(N_PLAYERS)-1:0]    o_ActiveSeat,
  output logic                            o_HitInd,
  output logic                            o_StayInd,
  output logic                            o_ShowDealer,
  output logic [N_PLAYERS-1:0]            o_Win,
  output logic [N_PLAYERS-1:0]            o_Lose,
  output logic [N_PLAYERS-1:0]            o_Tie
);

  localparam int unsigned SEAT_W     = seat_w(N_PLAYERS);
  localparam int unsigned N_SEATS    = N_PLAYERS + 1;
  localparam int unsigned DEAL_CARDS = 2 * N_SEATS;
  localparam int unsigned DEAL_W     = $clog2(DEAL_CARDS);
  localparam int unsigned CNT_W      = (DISPLAY_CYC > 1) ? $clog2(DISPLAY_CYC) : 1;

  localparam logic [HAND_W-1:0] LIMIT  = HAND_W'(BUST_LIMIT);
  localparam logic [HAND_W-1:0] STAND  = HAND_W'(STAND_AT);
  localparam logic [SEAT_W-1:0] LAST_P = SEAT_W'(N_PLAYERS - 1);
  localparam logic [SEAT_W-1:0] DEALER = SEAT_W'(N_PLAYERS);

  state_t              state_q, next_state;
  logic [DEAL_W-1:0]   deal_idx_q, deal_idx_d;
  logic [SEAT_W-1:0]   seat_q;
  logic [CNT_W-1:0]    hold_cnt_q;
  logic                hold_hit_q, hold_hit_d;
  logic [N_PLAYERS-1:0] bust_q;
  logic                d_nat_q;

  logic                hit_edge, stay_edge, newgame_edge;

  logic [HAND_W-1:0]   hand [N_SEATS];
  logic [HAND_W-1:0]   seat_hand;
  logic [HAND_W-1:0]   dealer_hand;
  logic                dealer_hits;
  logic                deal_last;
  logic                hold_done;
  logic                in_hold;
  logic                all_bust;

  logic                shuffle_req_d, card_req_d, hit_ind_d, stay_ind_d, show_dealer_d;
  logic [SEAT_W-1:0]   card_dest_d;
  logic [N_PLAYERS-1:0] win_d, lose_d, tie_d;
  result_t             seat_res [N_PLAYERS];

  bj_edge_det u_hit_edge (
    .i_Clk    (i_Clk),
    .i_Reset_n(i_Reset_n),
    .level    (i_Hit),
    .rise     (hit_edge)
  );

  bj_edge_det u_stay_edge (
    .i_Clk    (i_Clk),
    .i_Reset_n(i_Reset_n),
    .level    (i_Stay),
    .rise     (stay_edge)
  );

  bj_edge_det u_newgame_edge (
    .i_Clk    (i_Clk),
    .i_Reset_n(i_Reset_n),
    .level    (i_NewGame),
    .rise     (newgame_edge)
  );

  // Deal order cycles P0..P(N-1), D twice.
  function automatic logic [SEAT_W-1:0] deal_dest(input logic [DEAL_W-1:0] idx);
    if (idx < DEAL_W'(N_SEATS)) return SEAT_W'(idx);
    return SEAT_W'(idx - DEAL_W'(N_SEATS));
  endfunction

  always_comb begin
    seat_hand = '0;
    for (int unsigned k = 0; k < N_SEATS; k++) begin
      hand[k] = i_Hands[k*HAND_W +: HAND_W];
      if (seat_q == SEAT_W'(k)) seat_hand = i_Hands[k*HAND_W +: HAND_W];
    end
  end

  assign dealer_hand = i_Hands[N_PLAYERS*HAND_W +: HAND_W];
  assign deal_last   = (deal_idx_q == DEAL_W'(DEAL_CARDS - 1));
  assign hold_done   = (hold_cnt_q == CNT_W'(DISPLAY_CYC - 1));
  assign in_hold     = (state_q == P_HOLD) || (state_q == D_HOLD);
  assign all_bust    = &bust_q;
  assign o_ActiveSeat = seat_q;

`ifdef BJ_SOFT17_HIT_EN
  assign dealer_hits = (dealer_hand < STAND) || ((dealer_hand == STAND) && i_DealerSoft);
`else
  assign dealer_hits = (dealer_hand < STAND);
`endif

  // State register
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) state_q <= IDLE;
    else            state_q <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      IDLE:    next_state = SHUFFLE;
      SHUFFLE: if (i_Shuffled) next_state = DEAL;
      DEAL:    if (i_CardOK && deal_last) next_state = PEEK;
      PEEK:    next_state = (dealer_hand == LIMIT) ? SETTLE : P_TURN;
      // A hand sitting at the limit cannot improve, so the seat is stayed
      // without a hold; after the deal this is exactly the natural case.
      P_TURN: begin
        if (seat_hand == LIMIT) next_state = NEXT_P;
        else if (hit_edge)      next_state = P_CARD;
        else if (stay_edge)     next_state = P_HOLD;
      end
      P_CARD:  if (i_CardOK) next_state = P_HOLD;
      P_HOLD: begin
        if (hold_done) begin
          if (hold_hit_q) next_state = (seat_hand > LIMIT) ? NEXT_P : P_TURN;
          else            next_state = NEXT_P;
        end
      end
      NEXT_P: begin
        if (seat_q == LAST_P) next_state = all_bust ? SETTLE : D_TURN;
        else                  next_state = P_TURN;
      end
      D_TURN:  next_state = dealer_hits ? D_CARD : D_HOLD;
      D_CARD:  if (i_CardOK) next_state = D_HOLD;
      D_HOLD: begin
        if (hold_done) begin
          if (hold_hit_q && (dealer_hand <= LIMIT)) next_state = D_TURN;
          else                                      next_state = SETTLE;
        end
      end
      SETTLE:  next_state = DONE;
      DONE:    if (newgame_edge) next_state = SHUFFLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: next-cycle values for the registered outputs, decoded from
  // the state being entered so they line up with the state register.
  always_comb begin
    deal_idx_d    = '0;
    hold_hit_d    = hold_hit_q;
    shuffle_req_d = (next_state == SHUFFLE);
    card_req_d    = 1'b0;
    card_dest_d   = '0;
    show_dealer_d = 1'b0;

    if (state_q == DEAL)
      deal_idx_d = i_CardOK ? deal_idx_q + DEAL_W'(1) : deal_idx_q;

    if ((state_q == P_CARD) || (state_q == D_CARD)) hold_hit_d = 1'b1;
    else if ((state_q == P_TURN) || (state_q == D_TURN)) hold_hit_d = 1'b0;

    unique case (next_state)
      // One idle cycle after each i_CardOK separates consecutive deal requests.
      DEAL: begin
        card_req_d  = !((state_q == DEAL) && i_CardOK);
        card_dest_d = deal_dest(deal_idx_d);
      end
      P_CARD: begin
        card_req_d  = 1'b1;
        card_dest_d = seat_q;
      end
      D_CARD: begin
        card_req_d  = 1'b1;
        card_dest_d = DEALER;
      end
      default: ;
    endcase

    unique case (next_state)
      D_TURN, D_CARD, D_HOLD, SETTLE, DONE: show_dealer_d = 1'b1;
      default: ;
    endcase

    hit_ind_d  = ((next_state == P_HOLD) || (next_state == D_HOLD)) &&  hold_hit_d;
    stay_ind_d = ((next_state == P_HOLD) || (next_state == D_HOLD)) && !hold_hit_d;

    win_d  = '0;
    lose_d = '0;
    tie_d  = '0;
    for (int unsigned k = 0; k < N_PLAYERS; k++) begin
      seat_res[k] = RES_LOSE;
      if (bust_q[k])                 seat_res[k] = RES_LOSE;
      else if (d_nat_q)              seat_res[k] = (hand[k] == LIMIT) ? RES_TIE : RES_LOSE;
      else if (dealer_hand > LIMIT)  seat_res[k] = RES_WIN;
      else if (hand[k] > dealer_hand) seat_res[k] = RES_WIN;
      else if (hand[k] == dealer_hand) seat_res[k] = RES_TIE;
      else                           seat_res[k] = RES_LOSE;
      win_d[k]  = (seat_res[k] == RES_WIN);
      lose_d[k] = (seat_res[k] == RES_LOSE);
      tie_d[k]  = (seat_res[k] == RES_TIE);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      deal_idx_q   <= '0;
      seat_q       <= '0;
      hold_cnt_q   <= '0;
      hold_hit_q   <= 1'b0;
      bust_q       <= '0;
      d_nat_q      <= 1'b0;
      o_ShuffleReq <= 1'b0;
      o_CardReq    <= 1'b0;
      o_CardDest   <= '0;
      o_HitInd     <= 1'b0;
      o_StayInd    <= 1'b0;
      o_ShowDealer <= 1'b0;
      o_Win        <= '0;
      o_Lose       <= '0;
      o_Tie        <= '0;
    end else begin
      deal_idx_q   <= deal_idx_d;
      hold_hit_q   <= hold_hit_d;
      o_ShuffleReq <= shuffle_req_d;
      o_CardReq    <= card_req_d;
      o_CardDest   <= card_dest_d;
      o_HitInd     <= hit_ind_d;
      o_StayInd    <= stay_ind_d;
      o_ShowDealer <= show_dealer_d;

      // Counter idles at zero, so each hold starts from zero on entry.
      if (in_hold && !hold_done) hold_cnt_q <= hold_cnt_q + CNT_W'(1);
      else                       hold_cnt_q <= '0;

      if (state_q == PEEK) d_nat_q <= (dealer_hand == LIMIT);

      if ((state_q == P_HOLD) && hold_done && hold_hit_q && (seat_hand > LIMIT)) begin
        for (int unsigned k = 0; k < N_PLAYERS; k++)
          if (seat_q == SEAT_W'(k)) bust_q[k] <= 1'b1;
      end

      if (state_q == NEXT_P)
        seat_q <= (seat_q == LAST_P) ? DEALER : seat_q + SEAT_W'(1);

      if (state_q == SETTLE) begin
        o_Win  <= win_d;
        o_Lose <= lose_d;
        o_Tie  <= tie_d;
      end

      if ((state_q == DONE) && newgame_edge) begin
        o_Win   <= '0;
        o_Lose  <= '0;
        o_Tie   <= '0;
        bust_q  <= '0;
        seat_q  <= '0;
        d_nat_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bj_table_controller.sv
`timescale 1ns/1ps
module tb_bj_table_controller;

  localparam int HW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, hit, stay, newgame, shuffled, card_ok;
  logic [HW-1:0] h0, h1, h2;
  logic [3*HW-1:0] hands;
  assign hands = {h2, h1, h0};

  logic shuffle_req, card_req, hit_ind, stay_ind, show_dealer;
  logic [1:0] card_dest, active_seat, win, lose, tie;

  int checks = 0;
  int errors = 0;

  bj_table_controller #(
    .N_PLAYERS  (2),
    .HAND_W     (HW),
    .BUST_LIMIT (21),
    .STAND_AT   (17),
    .DISPLAY_CYC(4)
  ) dut (
    .i_Clk       (clk),
    .i_Reset_n   (rst_n),
    .i_Hit       (hit),
    .i_Stay      (stay),
    .i_NewGame   (newgame),
    .i_Shuffled  (shuffled),
    .i_CardOK    (card_ok),
`ifdef BJ_SOFT17_HIT_EN
    .i_DealerSoft(1'b0),
`endif
    .i_Hands     (hands),
    .o_ShuffleReq(shuffle_req),
    .o_CardReq   (card_req),
    .o_CardDest  (card_dest),
    .o_ActiveSeat(active_seat),
    .o_HitInd    (hit_ind),
    .o_StayInd   (stay_ind),
    .o_ShowDealer(show_dealer),
    .o_Win       (win),
    .o_Lose      (lose),
    .o_Tie       (tie)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " shufreq"}, shuffle_req, 0);
    check({tag, " cardreq"}, card_req, 0);
    check({tag, " dest"}, card_dest, 0);
    check({tag, " seat"}, active_seat, 0);
    check({tag, " hitind"}, hit_ind, 0);
    check({tag, " stayind"}, stay_ind, 0);
    check({tag, " show"}, show_dealer, 0);
    check({tag, " win"}, win, 0);
    check({tag, " lose"}, lose, 0);
    check({tag, " tie"}, tie, 0);
  endtask

  task automatic press(input logic h, input logic s, input logic ng);
    hit = h; stay = s; newgame = ng;
    tick();
    hit = 1'b0; stay = 1'b0; newgame = 1'b0;
  endtask

  task automatic wait_card(input string tag);
    int n = 0;
    while (card_req !== 1'b1 && n < 100) begin tick(); n++; end
    check({tag, " req"}, card_req, 1);
  endtask

  task automatic serve(input string tag, input int dest, input int seat, input int val);
    wait_card(tag);
    check({tag, " dest"}, card_dest, dest);
    card_ok = 1'b1;
    case (seat)
      0:       h0 = HW'(val);
      1:       h1 = HW'(val);
      default: h2 = HW'(val);
    endcase
    tick();
    card_ok = 1'b0;
    check({tag, " drop"}, card_req, 0);
  endtask

  task automatic do_shuffle(input string tag);
    int n = 0;
    while (shuffle_req !== 1'b1 && n < 100) begin tick(); n++; end
    check({tag, " shufreq"}, shuffle_req, 1);
    shuffled = 1'b1;
    tick();
    shuffled = 1'b0;
    check({tag, " shufdrop"}, shuffle_req, 0);
  endtask

  task automatic deal(input string tag, input int a0, input int a1, input int ad,
                      input int b0, input int b1, input int bd);
    serve({tag, " deal1"}, 0, 0, a0);
    serve({tag, " deal2"}, 1, 1, a1);
    serve({tag, " deal3"}, 2, 2, ad);
    serve({tag, " deal4"}, 0, 0, b0);
    serve({tag, " deal5"}, 1, 1, b1);
    serve({tag, " deal6"}, 2, 2, bd);
  endtask

  task automatic hold_len(input string tag, input bit hit_sel, input int exp);
    int n = 0;
    int w = 0;
    while ((hit_sel ? hit_ind : stay_ind) !== 1'b1 && w < 100) begin tick(); w++; end
    while ((hit_sel ? hit_ind : stay_ind) === 1'b1 && n < 100) begin n++; tick(); end
    check(tag, n, exp);
  endtask

  task automatic wait_seat(input string tag, input int seat);
    int n = 0;
    while (active_seat !== 2'(seat) && n < 100) begin tick(); n++; end
    check(tag, active_seat, seat);
  endtask

  task automatic wait_result(output int reqs, output int inds);
    int n = 0;
    reqs = 0;
    inds = 0;
    while ((win | lose | tie) === 2'b00 && n < 100) begin
      if (card_req === 1'b1) reqs++;
      if (hit_ind === 1'b1 || stay_ind === 1'b1) inds++;
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs, inds, n;
    rst_n = 1'b0; hit = 1'b0; stay = 1'b0; newgame = 1'b0;
    shuffled = 1'b0; card_ok = 1'b0;
    h0 = '0; h1 = '0; h2 = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Round 1: hit held through the deal is ignored; seat0 busts, seat1 beats dealer 17
    do_shuffle("r1");
    hit = 1'b1;
    deal("r1", 10, 10, 10, 14, 18, 17);
    hit = 1'b0;
    n = 0;
    repeat (6) begin tick(); if (card_req === 1'b1) n++; end
    check("r1 held hit ignored", n, 0);
    check("r1 first seat", active_seat, 0);
    press(1, 0, 0);
    serve("r1 hit", 0, 0, 24);
    check("r1 hitind first", hit_ind, 1);
    hold_len("r1 hit hold", 1, 4);
    wait_seat("r1 seat1", 1);
    check("r1 lose pre", lose, 0);
    press(0, 1, 0);
    hold_len("r1 stay hold", 0, 4);
    wait_seat("r1 dealer seat", 2);
    check("r1 show dealer turn", show_dealer, 1);
    hold_len("r1 dealer stay", 0, 4);
    check("r1 win pre", win, 0);
    wait_result(reqs, inds);
    check("r1 win", win, 2'b10);
    check("r1 lose", lose, 2'b01);
    check("r1 tie", tie, 2'b00);
    check("r1 show", show_dealer, 1);

    // Round 2: dealer natural settles directly
    press(0, 0, 1);
    do_shuffle("r2");
    check("r2 cleared win", win, 0);
    check("r2 cleared lose", lose, 0);
    check("r2 seat", active_seat, 0);
    deal("r2", 10, 10, 10, 21, 20, 21);
    wait_result(reqs, inds);
    check("r2 no card", reqs, 0);
    check("r2 no hold", inds, 0);
    check("r2 tie", tie, 2'b01);
    check("r2 lose", lose, 2'b10);
    check("r2 win", win, 2'b00);

    // Round 3: both seats bust, dealer draws nothing
    press(0, 0, 1);
    do_shuffle("r3");
    deal("r3", 10, 10, 10, 15, 16, 10);
    press(1, 0, 0);
    serve("r3 hit0", 0, 0, 25);
    hold_len("r3 hold0", 1, 4);
    wait_seat("r3 seat1", 1);
    press(1, 0, 0);
    serve("r3 hit1", 1, 1, 22);
    hold_len("r3 hold1", 1, 4);
    wait_result(reqs, inds);
    check("r3 no dealer card", reqs, 0);
    check("r3 lose", lose, 2'b11);
    check("r3 win", win, 2'b00);
    check("r3 tie", tie, 2'b00);

    // Round 4: dealer hits 16, busts at 23
    press(0, 0, 1);
    do_shuffle("r4");
    deal("r4", 10, 10, 10, 19, 15, 16);
    press(0, 1, 0);
    hold_len("r4 stay0", 0, 4);
    wait_seat("r4 seat1", 1);
    press(1, 0, 0);
    serve("r4 hit1", 1, 1, 26);
    hold_len("r4 hold1", 1, 4);
    wait_seat("r4 dealer seat", 2);
    serve("r4 dealer card", 2, 2, 23);
    hold_len("r4 dealer hold", 1, 4);
    wait_result(reqs, inds);
    check("r4 win", win, 2'b01);
    check("r4 lose", lose, 2'b10);
    check("r4 tie", tie, 2'b00);

    // Round 5: simultaneous hit+stay takes the hit; reset during dealer card
    press(0, 0, 1);
    do_shuffle("r5");
    deal("r5", 5, 5, 5, 10, 10, 10);
    press(1, 1, 0);
    serve("r5 both", 0, 0, 15);
    check("r5 no stayind", stay_ind, 0);
    hold_len("r5 hit hold", 1, 4);
    check("r5 still seat0", active_seat, 0);
    press(0, 1, 0);
    hold_len("r5 stay0", 0, 4);
    wait_seat("r5 seat1", 1);
    press(0, 1, 0);
    hold_len("r5 stay1", 0, 4);
    wait_card("r5 dealer");
    check("r5 dealer dest", card_dest, 2);
    rst_n = 1'b0;
    tick();
    check_all_zero("r5 reset");
    rst_n = 1'b1;
    n = 0;
    while (shuffle_req !== 1'b1 && n < 20) begin tick(); n++; end
    check("r5 restart shuffle", shuffle_req, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
